mem_access_stage: RTL and testbench

- Consumer side of the execute-stage outputs: ALU result, write-register address and rt store data, plus the memory/writeback control bus.
- Registers the incoming EX result and performs the load/store against a handshaked data memory.
- Stalls the execute stage while a memory access is outstanding.
- Delivers a single-cycle writeback packet (value, destination register, write enable) to the register file.

---
 rtl/mem_access_stage_pkg.sv | 25 ++
 rtl/mem_access_stage_load_store_align.sv | 52 +++++
 rtl/mem_access_stage.sv | 124 ++++++++++++
 tb/tb_mem_access_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: control-bus bit
// positions, access-size encodings and FSM state encodings.
package mem_access_stage_pkg;

  localparam int MEM_READ   = 0;
  localparam int MEM_WRITE  = 1;
  localparam int MEM_TO_REG = 2;
  localparam int REG_WRITE  = 3;
  localparam int SIZE_LO    = 4;
  localparam int SIZE_HI    = 5;
  localparam int LD_UNS     = 6;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Combinational lane logic: store replication and byte enables, load lane
// extraction with sign/zero extension, and the alignment check.
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] addr,
  input  size_e       size,
  input  logic        is_store,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] rdata_shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign rdata_shifted = rdata >> {addr[1:0], 3'b000};
  assign byte_lane     = rdata_shifted[7:0];
  assign half_lane     = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    wdata      = store_data;
    be         = 4'b1111;
    load_data  = rdata;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        wdata     = {4{store_data[7:0]}};
        load_data = load_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        if (is_store) be = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        wdata      = {2{store_data[15:0]}};
        load_data  = load_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        misaligned = addr[0];
        if (is_store) be = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        // Word and the reserved encoding both behave as a full word.
        misaligned = (addr[1:0] != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: accepts EX results, performs handshaked loads/stores,
// stalls EX while an access is outstanding and emits a one-cycle writeback.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_BUS_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_in,
  output logic                     ex_ready_out,
  input  logic                     flush_in,
  input  logic [MEM_BUS_WIDTH-1:0] mem_bus_in,
  input  logic [DATA_WIDTH-1:0]    alu_result_in,
  input  logic [DATA_WIDTH-1:0]    store_data_in,
  input  logic [REG_ADDR_BITS-1:0] reg_w_addr_in,
  output logic                     dmem_req_out,
  output logic                     dmem_we_out,
  output logic [DATA_WIDTH-1:0]    dmem_addr_out,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_out,
  output logic [3:0]               dmem_be_out,
  input  logic                     dmem_ack_in,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata_in,
  output logic                     wb_valid_out,
  output logic                     wb_reg_write_out,
  output logic [REG_ADDR_BITS-1:0] wb_reg_addr_out,
  output logic [DATA_WIDTH-1:0]    wb_data_out,
  output logic                     misaligned_err_out
);

  state_e                   state_q, state_d;
  logic [MEM_BUS_WIDTH-1:0] bus_q;
  logic [DATA_WIDTH-1:0]    addr_q, sdata_q;
  logic [REG_ADDR_BITS-1:0] rd_q;

  logic in_access, accept, is_mem_in, mis_in;
  logic [DATA_WIDTH-1:0] addr_sel, sdata_sel, st_wdata, ld_data;
  logic [3:0] st_be;
  logic       misaligned;

  assign in_access    = (state_q == ACCESS);
  assign ex_ready_out = (state_q == IDLE);
  assign accept       = ex_valid_in & ex_ready_out & ~flush_in;
  assign is_mem_in    = mem_bus_in[MEM_READ] | mem_bus_in[MEM_WRITE];
  assign mis_in       = is_mem_in & misaligned;

  // One lane unit serves both phases: the offered op in IDLE (alignment
  // check) and the latched op in ACCESS (store formatting, load extraction).
  assign addr_sel  = in_access ? addr_q  : alu_result_in;
  assign sdata_sel = in_access ? sdata_q : store_data_in;

  load_store_align u_align (
    .addr          (addr_sel),
    .size          (size_e'(in_access ? bus_q[SIZE_HI:SIZE_LO] : mem_bus_in[SIZE_HI:SIZE_LO])),
    .is_store      (bus_q[MEM_WRITE]),
    .load_unsigned (bus_q[LD_UNS]),
    .store_data    (sdata_sel),
    .rdata         (dmem_rdata_in),
    .wdata         (st_wdata),
    .be            (st_be),
    .load_data     (ld_data),
    .misaligned    (misaligned)
  );

  assign dmem_req_out   = in_access;
  assign dmem_we_out    = in_access & bus_q[MEM_WRITE];
  assign dmem_addr_out  = in_access ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem_wdata_out = in_access ? st_wdata : '0;
  assign dmem_be_out    = in_access ? st_be : 4'b0000;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_mem_in && !misaligned) state_d = ACCESS;
      ACCESS:  if (dmem_ack_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q              <= '0;
      addr_q             <= '0;
      sdata_q            <= '0;
      rd_q               <= '0;
      wb_valid_out       <= 1'b0;
      wb_reg_write_out   <= 1'b0;
      wb_reg_addr_out    <= '0;
      wb_data_out        <= '0;
      misaligned_err_out <= 1'b0;
    end else begin
      wb_valid_out       <= 1'b0;
      misaligned_err_out <= 1'b0;
      if (accept) begin
        bus_q   <= mem_bus_in;
        addr_q  <= alu_result_in;
        sdata_q <= store_data_in;
        rd_q    <= reg_w_addr_in;
        if (!is_mem_in || mis_in) begin
          wb_valid_out       <= 1'b1;
          wb_reg_write_out   <= mem_bus_in[REG_WRITE] & ~mis_in;
          wb_reg_addr_out    <= reg_w_addr_in;
          wb_data_out        <= alu_result_in;
          misaligned_err_out <= mis_in;
        end
      end else if (in_access && dmem_ack_in) begin
        wb_valid_out     <= 1'b1;
        wb_reg_write_out <= bus_q[REG_WRITE];
        wb_reg_addr_out  <= rd_q;
        wb_data_out      <= bus_q[MEM_TO_REG] ? ld_data : addr_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// ops against a behavioural model and a small word-addressed memory.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_in, ex_ready_out, flush_in;
  logic [6:0]  mem_bus_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  reg_w_addr_in;
  logic        dmem_req_out, dmem_we_out, dmem_ack_in;
  logic [31:0] dmem_addr_out, dmem_wdata_out, dmem_rdata_in;
  logic [3:0]  dmem_be_out;
  logic        wb_valid_out, wb_reg_write_out, misaligned_err_out;
  logic [4:0]  wb_reg_addr_out;
  logic [31:0] wb_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out), .flush_in(flush_in),
    .mem_bus_in(mem_bus_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .reg_w_addr_in(reg_w_addr_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_be_out(dmem_be_out), .dmem_ack_in(dmem_ack_in),
    .dmem_rdata_in(dmem_rdata_in),
    .wb_valid_out(wb_valid_out), .wb_reg_write_out(wb_reg_write_out),
    .wb_reg_addr_out(wb_reg_addr_out), .wb_data_out(wb_data_out),
    .misaligned_err_out(misaligned_err_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_mem;
    bit          is_store;
    bit          mis;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] wb_data;
    bit          wb_we;
  } exp_t;

  // Behavioural reference: works in byte counts and offsets, not bus lanes.
  function automatic exp_t model(input logic [6:0] bus, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rdata);
    exp_t e;
    int nb, off;
    logic [31:0] mask, lane;
    case (bus[5:4])
      2'd1:    nb = 2;
      2'd2:    nb = 1;
      default: nb = 4;
    endcase
    off        = int'(a % 4);
    e.is_mem   = bus[0] | bus[1];
    e.is_store = bus[1];
    e.mis      = e.is_mem && ((a % nb) != 0);
    e.daddr    = a - off;
    mask       = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    e.be       = e.is_store ? 4'(((1 << nb) - 1) << off) : 4'hF;
    e.wdata    = (nb == 1) ? sd[7:0] * 32'h0101_0101 :
                 (nb == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    lane       = (rdata >> (8 * off)) & mask;
    if (!bus[6] && nb < 4 && lane[8*nb-1]) lane = lane | ~mask;
    e.wb_data  = (e.is_mem && !e.mis && bus[2]) ? lane : a;
    e.wb_we    = e.mis ? 1'b0 : bus[3];
    return e;
  endfunction

  task automatic do_op(input logic [6:0] bus, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input bit flush, input int delay,
                       input logic [31:0] rdata, input bit flush_acc);
    exp_t e;
    int low;
    e = model(bus, a, sd, rdata);
    @(negedge clk);
    check("wb_pulse_ended", wb_valid_out, 1'b0);
    check("ready_idle", ex_ready_out, 1'b1);
    ex_valid_in = 1'b1; flush_in = flush; mem_bus_in = bus;
    alu_result_in = a; store_data_in = sd; reg_w_addr_in = rd;
    @(negedge clk);
    ex_valid_in = 1'b0; flush_in = 1'b0; mem_bus_in = 7'($urandom);
    alu_result_in = $urandom; store_data_in = $urandom; reg_w_addr_in = 5'($urandom);
    if (flush) begin
      check("flush_no_wb", wb_valid_out, 1'b0);
      check("flush_no_req", dmem_req_out, 1'b0);
      check("flush_ready", ex_ready_out, 1'b1);
      return;
    end
    if (!e.is_mem || e.mis) begin
      check("imm_wb_valid", wb_valid_out, 1'b1);
      check("imm_wb_data", wb_data_out, e.wb_data);
      check("imm_wb_we", wb_reg_write_out, e.wb_we);
      check("imm_wb_addr", wb_reg_addr_out, rd);
      check("imm_mis", misaligned_err_out, e.mis);
      check("imm_no_req", dmem_req_out, 1'b0);
      check("imm_ready", ex_ready_out, 1'b1);
      return;
    end
    check("acc_we", dmem_we_out, e.is_store);
    check("acc_be", dmem_be_out, e.be);
    if (e.is_store) check("acc_wdata", dmem_wdata_out, e.wdata);
    check("acc_no_wb", wb_valid_out, 1'b0);
    low = 0;
    for (int i = 0; i < delay; i++) begin
      if (!ex_ready_out) low++;
      check("acc_req_hold", dmem_req_out, 1'b1);
      check("acc_addr_hold", dmem_addr_out, e.daddr);
      if (flush_acc) begin ex_valid_in = 1'b1; flush_in = 1'b1; end
      @(negedge clk);
    end
    if (!ex_ready_out) low++;
    check("acc_req_last", dmem_req_out, 1'b1);
    check("acc_addr_last", dmem_addr_out, e.daddr);
    ex_valid_in = 1'b0; flush_in = 1'b0;
    dmem_ack_in = 1'b1; dmem_rdata_in = rdata;
    @(negedge clk);
    dmem_ack_in = 1'b0; dmem_rdata_in = $urandom;
    check("mem_wb_valid", wb_valid_out, 1'b1);
    check("mem_wb_data", wb_data_out, e.wb_data);
    check("mem_wb_we", wb_reg_write_out, e.wb_we);
    check("mem_wb_addr", wb_reg_addr_out, rd);
    check("mem_no_mis", misaligned_err_out, 1'b0);
    check("mem_req_drop", dmem_req_out, 1'b0);
    check("mem_ready_back", ex_ready_out, 1'b1);
    check("stall_cycles", low, delay + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [6:0]  bus;
    logic [31:0] a, bm;
    int kind;
    bit flush;

    rst_n = 1'b0; ex_valid_in = 1'b0; flush_in = 1'b0; mem_bus_in = '0;
    alu_result_in = '0; store_data_in = '0; reg_w_addr_in = '0;
    dmem_ack_in = 1'b0; dmem_rdata_in = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #23;
    check("rst_ready", ex_ready_out, 1'b1);
    check("rst_req", dmem_req_out, 1'b0);
    check("rst_be", dmem_be_out, 4'h0);
    check("rst_wb_valid", wb_valid_out, 1'b0);
    check("rst_wb_data", wb_data_out, 32'h0);
    check("rst_mis", misaligned_err_out, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Directed scenarios.
    do_op(7'h08, 32'h0000_0010, 32'h0, 5'd7, 1'b0, 0, 32'h0, 1'b0);
    do_op(7'h22, 32'h0000_0103, 32'h0000_00AB, 5'd3, 1'b0, 3, 32'h0, 1'b0);
    do_op(7'h1D, 32'h0000_0022, 32'h0, 5'd9, 1'b0, 1, 32'h8001_1234, 1'b0);
    do_op(7'h5D, 32'h0000_0022, 32'h0, 5'd9, 1'b0, 0, 32'h8001_1234, 1'b0);
    do_op(7'h0D, 32'h0000_0006, 32'h0, 5'd4, 1'b0, 0, 32'h0, 1'b0);
    do_op(7'h08, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b0);
    do_op(7'h0D, 32'h0000_0040, 32'h0, 5'd6, 1'b0, 2, 32'hCAFE_F00D, 1'b1);

    // Randomized ops against the model and a 16-word memory image.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom_range(0, 63);
      bus  = 7'($urandom);
      case (kind)
        0: begin bus[1:0] = 2'b00; a = $urandom; end
        1: bus[1:0] = 2'b01;
        2: begin bus[1:0] = 2'b10; bus[2] = 1'b0; end
        default: begin bus[1:0] = 2'b11; bus[2] = 1'b0; end
      endcase
      flush = ($urandom_range(0, 9) == 0);
      e = model(bus, a, $urandom, 32'h0);
      do_op(bus, a, $urandom, 5'($urandom), flush, $urandom_range(0, 4),
            mem[a[5:2]], 1'($urandom));
      if (!flush && e.is_store && !e.mis) begin
        e  = model(bus, a, store_data_in, 32'h0);
        bm = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
        mem[a[5:2]] = (mem[a[5:2]] & ~bm) | (e.wdata & bm);
      end
    end

    // Reset in the middle of an access; a late ack must be ignored.
    @(negedge clk);
    ex_valid_in = 1'b1; mem_bus_in = 7'h0D; alu_result_in = 32'h40; reg_w_addr_in = 5'd2;
    @(negedge clk);
    ex_valid_in = 1'b0;
    check("rstacc_req_before", dmem_req_out, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstacc_req_async", dmem_req_out, 1'b0);
    check("rstacc_ready", ex_ready_out, 1'b1);
    dmem_ack_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("late_ack_no_wb", wb_valid_out, 1'b0);
    check("late_ack_no_req", dmem_req_out, 1'b0);
    dmem_ack_in = 1'b0;
    @(negedge clk);
    check("late_ack_no_wb2", wb_valid_out, 1'b0);
    check("late_ack_ready", ex_ready_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
